// File: rtl/bus_rx_port.sv
// Receive endpoint of the shared tri-state bus: captures words from whichever single
// device holds the grant, tags them with the source, and queues them in a FWFT FIFO.
module bus_rx_port #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  bus_data,
  input  logic          grant1,
  input  logic          grant2,
  output logic [N-1:0]  out_data,
  output logic          out_src,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          rx_full,
  output logic [AW:0]   level,
  output logic          ovf_err,
  output logic          col_err,
  input  logic          clr_err
);

  logic [N:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic cap;
  logic collide;
  logic pop;
  logic wr;
  logic ovf;

  // Flags come only from the registered level, so the controller sees no input-to-output path.
  assign out_valid = (level != '0);
  assign rx_full   = (level == (AW+1)'(DEPTH));

  assign cap     = grant1 ^ grant2;
  assign collide = grant1 & grant2;
  assign pop     = out_valid & out_ready;
  assign wr      = cap & (~rx_full | pop);
  assign ovf     = cap & rx_full & ~pop;

  assign out_data = mem[rd_ptr][N-1:0];
  assign out_src  = mem[rd_ptr][N];

  // Storage needs no reset: the pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= {grant2, bus_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ovf_err <= 1'b0;
      col_err <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr && !pop) begin
        level <= level + (AW+1)'(1);
      end else if (pop && !wr) begin
        level <= level - (AW+1)'(1);
      end
      // A set event in the same cycle as clr_err wins.
      if (ovf) begin
        ovf_err <= 1'b1;
      end else if (clr_err) begin
        ovf_err <= 1'b0;
      end
      if (collide) begin
        col_err <= 1'b1;
      end else if (clr_err) begin
        col_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_rx_port.sv
// Directed bench for bus_rx_port: each task drives one scenario and checks
// hand-computed expectations inline.
module tb_bus_rx_port;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bus_data = 8'h00;
  logic       grant1 = 1'b0;
  logic       grant2 = 1'b0;
  logic [7:0] out_data;
  logic       out_src;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       rx_full;
  logic [2:0] level;
  logic       ovf_err;
  logic       col_err;
  logic       clr_err = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  bus_rx_port #(.N(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus_data(bus_data), .grant1(grant1), .grant2(grant2),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
    .rx_full(rx_full), .level(level), .ovf_err(ovf_err), .col_err(col_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled and inputs re-driven 1 ns later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    grant1 = 1'b0; grant2 = 1'b0; out_ready = 1'b0; clr_err = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d exp 0", level); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    n_cmp++; if (rx_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b exp 0", rx_full); end
    n_cmp++; if ({ovf_err, col_err} !== 2'b00) begin n_err++; $display("FAIL reset_errs: got %b%b exp 00", ovf_err, col_err); end
  endtask

  task automatic test_single_word();
    idle();
    grant1 = 1'b1; bus_data = 8'hA5;
    cycle();
    grant1 = 1'b0; bus_data = 8'hZZ;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b exp 1", out_valid); end
    n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h exp a5", out_data); end
    n_cmp++; if (out_src !== 1'b0) begin n_err++; $display("FAIL single_src: got %b exp 0", out_src); end
    n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL single_level: got %0d exp 1", level); end
    cycle();
    cycle();
    n_cmp++; if (out_data !== 8'hA5 || level !== 3'd1) begin n_err++; $display("FAIL single_hold: got %h/%0d exp a5/1", out_data, level); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    n_cmp++; if (level !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL single_pop: got level %0d valid %b exp 0/0", level, out_valid); end
  endtask

  task automatic test_fill_overflow();
    idle();
    grant2 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus_data = 8'(i);
      cycle();
    end
    n_cmp++; if (level !== 3'd4 || rx_full !== 1'b1) begin n_err++; $display("FAIL fill_full: got level %0d full %b exp 4/1", level, rx_full); end
    n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL fill_noovf: got %b exp 0", ovf_err); end
    bus_data = 8'h05;
    cycle();
    grant2 = 1'b0;
    n_cmp++; if (ovf_err !== 1'b1) begin n_err++; $display("FAIL fill_ovf: got %b exp 1", ovf_err); end
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL fill_ovf_level: got %0d exp 4", level); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (out_data !== 8'(i) || out_src !== 1'b1) begin n_err++; $display("FAIL fill_drain%0d: got %h/%b exp %h/1", i, out_data, out_src, 8'(i)); end
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
    end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL fill_empty: got %0d exp 0", level); end
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL fill_clr: got %b exp 0", ovf_err); end
  endtask

  task automatic test_full_pop_capture();
    idle();
    grant1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_data = 8'h10 + 8'(i);
      cycle();
    end
    bus_data = 8'h14; out_ready = 1'b1;
    cycle();
    grant1 = 1'b0; out_ready = 1'b0;
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL fullpc_level: got %0d exp 4", level); end
    n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL fullpc_ovf: got %b exp 0", ovf_err); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (out_data !== 8'h10 + 8'(i) || out_src !== 1'b0) begin n_err++; $display("FAIL fullpc_drain%0d: got %h/%b exp %h/0", i, out_data, out_src, 8'h10 + 8'(i)); end
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fullpc_empty: got %b exp 0", out_valid); end
  endtask

  task automatic test_collision();
    idle();
    grant1 = 1'b1; grant2 = 1'b1; bus_data = 8'hFF;
    cycle();
    grant1 = 1'b0; grant2 = 1'b0;
    n_cmp++; if (level !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL col_nocap: got level %0d valid %b exp 0/0", level, out_valid); end
    n_cmp++; if (col_err !== 1'b1) begin n_err++; $display("FAIL col_set: got %b exp 1", col_err); end
    cycle();
    n_cmp++; if (col_err !== 1'b1) begin n_err++; $display("FAIL col_sticky: got %b exp 1", col_err); end
    clr_err = 1'b1;
    cycle();
    n_cmp++; if (col_err !== 1'b0) begin n_err++; $display("FAIL col_clr: got %b exp 0", col_err); end
    grant1 = 1'b1; grant2 = 1'b1;
    cycle();
    grant1 = 1'b0; grant2 = 1'b0; clr_err = 1'b0;
    n_cmp++; if (col_err !== 1'b1) begin n_err++; $display("FAIL col_setwins: got %b exp 1", col_err); end
    n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL col_ovf: got %b exp 0", ovf_err); end
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
  endtask

  // Bench plays the bus controller: grants are withheld while rx_full is high.
  task automatic test_wrap_interleave();
    int sent = 0;
    int rcvd = 0;
    int max_level = 0;
    int budget = 0;
    idle();
    out_ready = 1'b1;
    while (rcvd < 12 && budget < 200) begin
      grant1 = 1'b0; grant2 = 1'b0;
      if (sent < 12 && !rx_full) begin
        bus_data = 8'(sent);
        if (sent % 2 == 0) grant1 = 1'b1; else grant2 = 1'b1;
        sent++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_data !== 8'(rcvd) || out_src !== 1'(rcvd % 2)) begin
          n_err++; $display("FAIL wrap_word%0d: got %h/%b exp %h/%0d", rcvd, out_data, out_src, 8'(rcvd), rcvd % 2);
        end
        rcvd++;
      end
      cycle();
      if (int'(level) > max_level) max_level = int'(level);
      out_ready = ~out_ready;
      budget++;
    end
    idle();
    n_cmp++; if (rcvd !== 12) begin n_err++; $display("FAIL wrap_count: got %0d exp 12", rcvd); end
    n_cmp++; if (max_level > 4) begin n_err++; $display("FAIL wrap_maxlevel: got %0d exp <=4", max_level); end
    n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL wrap_ovf: got %b exp 0", ovf_err); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL wrap_empty: got %0d exp 0", level); end
  endtask

  task automatic test_reset_mid();
    idle();
    grant2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_data = 8'h30 + 8'(i);
      cycle();
    end
    grant1 = 1'b1;
    cycle();
    grant1 = 1'b0; grant2 = 1'b0;
    n_cmp++; if (level !== 3'd3 || col_err !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got level %0d col %b exp 3/1", level, col_err); end
    rst = 1'b1; grant1 = 1'b1; bus_data = 8'h77;
    cycle();
    rst = 1'b0; grant1 = 1'b0;
    n_cmp++; if (level !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_level: got level %0d valid %b exp 0/0", level, out_valid); end
    n_cmp++; if ({ovf_err, col_err} !== 2'b00) begin n_err++; $display("FAIL rstmid_errs: got %b%b exp 00", ovf_err, col_err); end
    cycle();
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL rstmid_nostore: got %0d exp 0", level); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill_overflow();
    test_full_pop_capture();
    test_collision();
    test_wrap_interleave();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
